// File: rtl/max_unpooling_if.sv
// Valid/ready bundle for the max-unpooling stage: pooled beats in, unpooled samples out.
// The slave modport is the unpooling block and the master modport is its environment.
interface max_unpooling_if #(
    parameter int n_data = 16,
    parameter int idx_w  = 1
);
    logic              in_valid;
    logic              in_ready;
    logic [n_data-1:0] in_data;
    logic [idx_w-1:0]  in_idx;
    logic              out_valid;
    logic              out_ready;
    logic [n_data-1:0] out_data;
    logic              out_last;
    logic              idx_err;

    modport slave (
        input  in_valid, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_last, idx_err
    );

    modport master (
        output in_valid, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_last, idx_err
    );
endinterface

// File: rtl/max_unpooling.sv
// Streaming 1-D max-unpooling: each input beat expands into pooling_size samples.
// The sample at the recorded position carries the value and every other sample is zero.
module max_unpooling #(
    parameter int pooling_size = 2,
    parameter int n_data       = 16,
    parameter int idx_w        = $clog2(pooling_size)
) (
    input  logic           clk,
    input  logic           reset,
    max_unpooling_if.slave bus
);
    localparam int cnt_w = $clog2(pooling_size);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    generate
        if (pooling_size < 2) begin : g_bad_size
            $error("max_unpooling: pooling_size must be at least 2");
        end
        if (idx_w < 1 || idx_w < cnt_w) begin : g_bad_idx_w
            $error("max_unpooling: idx_w too narrow for pooling_size");
        end
    endgenerate

    logic [0:0]        state_reg,    state_next;
    logic [cnt_w-1:0]  cnt_reg,      cnt_next;
    logic [n_data-1:0] data_reg,     data_next;
    logic [idx_w-1:0]  idx_reg,      idx_next;
    logic [n_data-1:0] out_data_reg, out_data_next;
    logic              out_last_reg, out_last_next;
    logic              idx_err_reg,  idx_err_next;

    logic in_fire;
    logic out_fire;

    // A new window can be taken while the last sample of the current one leaves,
    // so consecutive windows stream without a bubble.
    assign bus.in_ready  = (state_reg == IDLE) ||
                           ((state_reg == EMIT) && out_last_reg && bus.out_ready);
    assign bus.out_valid = (state_reg == EMIT);
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.idx_err   = idx_err_reg;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        data_next     = data_reg;
        idx_next      = idx_reg;
        out_data_next = out_data_reg;
        out_last_next = out_last_reg;
        idx_err_next  = idx_err_reg;

        if (in_fire) begin
            // Output sample 0 is presented straight from the accepting edge.
            state_next    = EMIT;
            data_next     = bus.in_data;
            idx_next      = bus.in_idx;
            cnt_next      = '0;
            out_data_next = (bus.in_idx == '0) ? bus.in_data : '0;
            out_last_next = 1'b0;
            if (int'(bus.in_idx) >= pooling_size) begin
                idx_err_next = 1'b1;
            end
        end else if (out_fire) begin
            if (out_last_reg) begin
                state_next    = IDLE;
                cnt_next      = '0;
                out_data_next = '0;
                out_last_next = 1'b0;
            end else begin
                // An out-of-range idx_reg never equals cnt, so such windows emit only zeros.
                cnt_next      = cnt_reg + cnt_w'(1);
                out_data_next = (int'(cnt_next) == int'(idx_reg)) ? data_reg : '0;
                out_last_next = (int'(cnt_next) == pooling_size - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            data_reg     <= '0;
            idx_reg      <= '0;
            out_data_reg <= '0;
            out_last_reg <= 1'b0;
            idx_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            data_reg     <= data_next;
            idx_reg      <= idx_next;
            out_data_reg <= out_data_next;
            out_last_reg <= out_last_next;
            idx_err_reg  <= idx_err_next;
        end
    end
endmodule

// File: tb/tb_max_unpooling.sv
// Self-checking bench for max_unpooling: directed windows followed by random traffic,
// compared against a queue of the samples each accepted beat must produce.
module tb_max_unpooling;
    localparam int ps = 4;
    localparam int nd = 16;
    localparam int iw = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    max_unpooling_if #(.n_data(nd), .idx_w(iw)) bus ();

    max_unpooling #(.pooling_size(ps), .n_data(nd), .idx_w(iw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [nd-1:0] d;
        logic          l;
    } samp_t;

    samp_t expq[$];
    logic  exp_err = 1'b0;
    int    n_cmp   = 0;
    int    n_err   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later,
    // then advance the model by what the coming rising edge will transfer.
    task automatic cycle(input logic v, input logic [nd-1:0] d, input logic [iw-1:0] ix,
                         input logic ordy, input logic rst, output logic acc);
        logic  exp_rdy;
        samp_t s;
        @(negedge clk);
        reset         = rst;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_idx    = ix;
        bus.out_ready = ordy;
        #1;
        exp_rdy = (expq.size() == 0) || (expq.size() == 1 && ordy);
        check_eq("out_valid", 32'(bus.out_valid), 32'(expq.size() != 0));
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check_eq("idx_err", 32'(bus.idx_err), 32'(exp_err));
        if (expq.size() != 0) begin
            check_eq("out_data", 32'(bus.out_data), 32'(expq[0].d));
            check_eq("out_last", 32'(bus.out_last), 32'(expq[0].l));
        end
        acc = v && bus.in_ready && !rst;
        if (rst) begin
            expq.delete();
            exp_err = 1'b0;
        end else begin
            if (bus.out_valid && ordy && expq.size() != 0) begin
                $display("out  data=%04h last=%0d", bus.out_data, bus.out_last);
                void'(expq.pop_front());
            end
            if (acc) begin
                $display("in   data=%04h idx=%0d", d, ix);
                for (int i = 0; i < ps; i++) begin
                    s.d = (int'(ix) == i) ? d : '0;
                    s.l = (i == ps - 1);
                    expq.push_back(s);
                end
                if (int'(ix) >= ps) exp_err = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [nd-1:0] d, input logic [iw-1:0] ix);
        logic acc = 1'b0;
        for (int n = 0; n < 32 && !acc; n++) cycle(1'b1, d, ix, 1'b1, 1'b0, acc);
        check_eq("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, ordy, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        logic v, ordy, rst;
        logic [iw-1:0] ix;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_idx    = '0;
        bus.out_ready = 1'b0;

        // Reset held for two cycles, then the idle outputs are all zero.
        cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
        idle(1, 1'b1);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_out_last", 32'(bus.out_last), 32'd0);

        // Basic expand, then back-to-back windows with in_valid held.
        send(16'h1234, 3'd1);
        idle(ps + 1, 1'b1);
        send(16'h00AA, 3'd0);
        send(16'hFF00, 3'd3);
        idle(ps + 1, 1'b1);

        // Backpressure on the second sample.
        send(16'h5A5A, 3'd1);
        idle(1, 1'b1);
        idle(3, 1'b0);
        idle(ps, 1'b1);

        // Out-of-range index, followed by a normal window with the flag still set.
        send(16'hBEEF, 3'd5);
        idle(ps, 1'b1);
        send(16'h0F0F, 3'd2);
        idle(ps + 1, 1'b1);

        // Reset after the first sample of a window, then a clean window.
        send(16'hCAFE, 3'd3);
        idle(1, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, acc);
        idle(1, 1'b1);
        send(16'h7777, 3'd2);
        idle(ps + 1, 1'b1);

        // Random traffic with occasional bad indices and rare resets.
        for (int i = 0; i < 1500; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 299) == 0);
            ix   = ($urandom_range(0, 9) == 0) ? iw'($urandom_range(ps, 7))
                                               : iw'($urandom_range(0, ps - 1));
            cycle(v, nd'($urandom), ix, ordy, rst, acc);
        end
        idle(ps + 1, 1'b1);
        check_eq("drained", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
